// File: rtl/hazard_scoreboard_if.sv
// ID-stage request and forwarding/stall control bundle of the hazard scoreboard.
// The slave side is the scoreboard; the master side is the pipeline driving it.
interface hazard_scoreboard_if;
   logic       id_valid;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       id_uses_rs;
   logic       id_uses_rt;
   logic [4:0] id_rd;
   logic       id_regWr;
   logic       id_memRd;
   logic       ex_branch_taken;
   logic       mem_wait;
   logic       stall;
   logic       flush_if_id;
   logic       flush_id_ex;
   logic [4:0] EX_reg;
   logic       EX_regWr;
   logic [4:0] MEM_reg;
   logic       MEM_regWr;
   logic [4:0] WB_reg;
   logic       WB_regWr;
   logic [1:0] fwd_a_sel;
   logic [1:0] fwd_b_sel;

   modport master (
      output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd, id_regWr, id_memRd,
             ex_branch_taken, mem_wait,
      input  stall, flush_if_id, flush_id_ex, EX_reg, EX_regWr, MEM_reg, MEM_regWr,
             WB_reg, WB_regWr, fwd_a_sel, fwd_b_sel
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd, id_regWr, id_memRd,
             ex_branch_taken, mem_wait,
      output stall, flush_if_id, flush_id_ex, EX_reg, EX_regWr, MEM_reg, MEM_regWr,
             WB_reg, WB_regWr, fwd_a_sel, fwd_b_sel
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// EX/MEM/WB shadow slots driving load-use stall, branch flush and forward selects.
// Define HAZARD_PERF_COUNTERS_EN to add stall/flush performance counter outputs.
module hazard_scoreboard #(
   parameter int LOAD_USE_STALL = 1
) (
   input  logic               clk,
   input  logic               reset_n,
   hazard_scoreboard_if.slave bus
`ifdef HAZARD_PERF_COUNTERS_EN
   ,
   output logic [31:0]        perf_stall_cnt,
   output logic [31:0]        perf_flush_cnt
`endif
);
   logic [4:0] ex_reg, mem_reg, wb_reg;
   logic       ex_wr, ex_ld, mem_wr, mem_ld, wb_wr;
   logic [1:0] sel_a, sel_b, sel_a_d, sel_b_d;
   logic       match_rs, match_rt, hazard, flush, bubble, rd_wr;

   // A load in MEM only blocks its consumer when data arrives at the end of WB.
   always_comb begin
      match_rs = (ex_wr && ex_ld && ex_reg == bus.id_rs)
              || (LOAD_USE_STALL == 2 && mem_wr && mem_ld && mem_reg == bus.id_rs);
      match_rt = (ex_wr && ex_ld && ex_reg == bus.id_rt)
              || (LOAD_USE_STALL == 2 && mem_wr && mem_ld && mem_reg == bus.id_rt);
      hazard   = bus.id_valid
              && ((bus.id_uses_rs && bus.id_rs != 5'd0 && match_rs)
               || (bus.id_uses_rt && bus.id_rt != 5'd0 && match_rt));
      flush    = bus.ex_branch_taken && !bus.mem_wait;
      bubble   = hazard || bus.ex_branch_taken || !bus.id_valid;
      rd_wr    = bus.id_regWr && bus.id_rd != 5'd0;

      sel_a_d = 2'd0;
      if (bus.id_uses_rs && bus.id_rs != 5'd0) begin
         if (ex_wr && ex_reg == bus.id_rs)        sel_a_d = 2'd1;
         else if (mem_wr && mem_reg == bus.id_rs) sel_a_d = 2'd2;
      end
      sel_b_d = 2'd0;
      if (bus.id_uses_rt && bus.id_rt != 5'd0) begin
         if (ex_wr && ex_reg == bus.id_rt)        sel_b_d = 2'd1;
         else if (mem_wr && mem_reg == bus.id_rt) sel_b_d = 2'd2;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ex_reg  <= 5'd0;
         ex_wr   <= 1'b0;
         ex_ld   <= 1'b0;
         mem_reg <= 5'd0;
         mem_wr  <= 1'b0;
         mem_ld  <= 1'b0;
         wb_reg  <= 5'd0;
         wb_wr   <= 1'b0;
         sel_a   <= 2'd0;
         sel_b   <= 2'd0;
      end else if (!bus.mem_wait) begin
         wb_reg  <= mem_reg;
         wb_wr   <= mem_wr;
         mem_reg <= ex_reg;
         mem_wr  <= ex_wr;
         mem_ld  <= ex_ld;
         if (bubble) begin
            ex_reg <= 5'd0;
            ex_wr  <= 1'b0;
            ex_ld  <= 1'b0;
            sel_a  <= 2'd0;
            sel_b  <= 2'd0;
         end else begin
            ex_reg <= bus.id_rd;
            ex_wr  <= rd_wr;
            ex_ld  <= bus.id_memRd;
            sel_a  <= sel_a_d;
            sel_b  <= sel_b_d;
         end
      end
   end

   assign bus.stall       = (hazard && !bus.ex_branch_taken) || bus.mem_wait;
   assign bus.flush_if_id = flush;
   assign bus.flush_id_ex = flush;
   assign bus.EX_reg      = ex_reg;
   assign bus.EX_regWr    = ex_wr;
   assign bus.MEM_reg     = mem_reg;
   assign bus.MEM_regWr   = mem_wr;
   assign bus.WB_reg      = wb_reg;
   assign bus.WB_regWr    = wb_wr;
   assign bus.fwd_a_sel   = sel_a;
   assign bus.fwd_b_sel   = sel_b;

`ifdef HAZARD_PERF_COUNTERS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_stall_cnt <= 32'd0;
         perf_flush_cnt <= 32'd0;
      end else begin
         if (hazard && !bus.ex_branch_taken && !bus.mem_wait)
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         if (flush)
            perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two instances (load-use latency 1 and 2) share stimulus
// and are compared against an instruction-level pipeline model.
module tb_hazard_scoreboard;
   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   hazard_scoreboard_if bus1 ();
   hazard_scoreboard_if bus2 ();

`ifdef HAZARD_PERF_COUNTERS_EN
   logic [31:0] ps1, pf1, ps2, pf2;
   logic [31:0] snap [2];
`endif

   hazard_scoreboard #(.LOAD_USE_STALL(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .bus(bus1.slave)
`ifdef HAZARD_PERF_COUNTERS_EN
      , .perf_stall_cnt(ps1), .perf_flush_cnt(pf1)
`endif
   );
   hazard_scoreboard #(.LOAD_USE_STALL(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .bus(bus2.slave)
`ifdef HAZARD_PERF_COUNTERS_EN
      , .perf_stall_cnt(ps2), .perf_flush_cnt(pf2)
`endif
   );

   typedef struct packed {
      logic       stall, fif, fie;
      logic [4:0] exr;
      logic       exw;
      logic [4:0] memr;
      logic       memw;
      logic [4:0] wbr;
      logic       wbw;
      logic [1:0] sa, sb;
   } out_t;

   typedef struct packed {
      logic [4:0] rd;
      logic       wr;
      logic       ld;
   } ins_t;

   int checks = 0;
   int failures = 0;

   // current ID-stage inputs
   logic       v, urs, urt, wr, ld, br, mw;
   logic [4:0] rs, rt, rd;

   // model: pipe[k][0]=EX, [1]=MEM, [2]=WB ; k=0 -> latency 1, k=1 -> latency 2
   ins_t        pipe [2][3];
   logic [1:0]  msel_a [2];
   logic [1:0]  msel_b [2];
   logic [31:0] m_ps [2];
   logic [31:0] m_pf [2];
   out_t        exp_pre [2], got_pre [2], exp_post [2], got_post [2];

   task automatic set_ins(input logic iv, input logic [4:0] irs, input logic iurs,
                          input logic [4:0] irt, input logic iurt,
                          input logic [4:0] ird, input logic iwr, input logic ild);
      v = iv; rs = irs; urs = iurs; rt = irt; urt = iurt; rd = ird; wr = iwr; ld = ild;
   endtask

   task automatic apply();
      bus1.id_valid = v;  bus1.id_rs = rs; bus1.id_rt = rt; bus1.id_uses_rs = urs;
      bus1.id_uses_rt = urt; bus1.id_rd = rd; bus1.id_regWr = wr; bus1.id_memRd = ld;
      bus1.ex_branch_taken = br; bus1.mem_wait = mw;
      bus2.id_valid = v;  bus2.id_rs = rs; bus2.id_rt = rt; bus2.id_uses_rs = urs;
      bus2.id_uses_rt = urt; bus2.id_rd = rd; bus2.id_regWr = wr; bus2.id_memRd = ld;
      bus2.ex_branch_taken = br; bus2.mem_wait = mw;
   endtask

   function automatic out_t got_out(int k);
      if (k == 0)
         return {bus1.stall, bus1.flush_if_id, bus1.flush_id_ex, bus1.EX_reg, bus1.EX_regWr,
                 bus1.MEM_reg, bus1.MEM_regWr, bus1.WB_reg, bus1.WB_regWr,
                 bus1.fwd_a_sel, bus1.fwd_b_sel};
      return {bus2.stall, bus2.flush_if_id, bus2.flush_id_ex, bus2.EX_reg, bus2.EX_regWr,
              bus2.MEM_reg, bus2.MEM_regWr, bus2.WB_reg, bus2.WB_regWr,
              bus2.fwd_a_sel, bus2.fwd_b_sel};
   endfunction

   // A load still in one of the first (latency) slots cannot supply its consumer yet.
   function automatic logic m_hazard(int k);
      logic h = 1'b0;
      for (int i = 0; i < k + 1; i++)
         if (pipe[k][i].wr && pipe[k][i].ld &&
             ((urs && rs != 5'd0 && pipe[k][i].rd == rs) ||
              (urt && rt != 5'd0 && pipe[k][i].rd == rt)))
            h = 1'b1;
      return v && h;
   endfunction

   // Youngest in-flight writer of r wins; position 0 will be MEM, 1 will be WB.
   function automatic logic [1:0] m_sel(int k, logic [4:0] r, logic used);
      if (!used || r == 5'd0) return 2'd0;
      for (int i = 0; i < 2; i++)
         if (pipe[k][i].wr && pipe[k][i].rd == r) return 2'(i + 1);
      return 2'd0;
   endfunction

   function automatic out_t m_out(int k);
      out_t o;
      o.stall = (m_hazard(k) && !br) || mw;
      o.fif   = br && !mw;
      o.fie   = br && !mw;
      o.exr   = pipe[k][0].rd;  o.exw  = pipe[k][0].wr;
      o.memr  = pipe[k][1].rd;  o.memw = pipe[k][1].wr;
      o.wbr   = pipe[k][2].rd;  o.wbw  = pipe[k][2].wr;
      o.sa    = msel_a[k];      o.sb   = msel_b[k];
      return o;
   endfunction

   task automatic m_advance(int k);
      logic h, bub;
      h = m_hazard(k);
      if (!mw) begin
         bub = h || br || !v;
         msel_a[k] = bub ? 2'd0 : m_sel(k, rs, urs);
         msel_b[k] = bub ? 2'd0 : m_sel(k, rt, urt);
         if (h && !br) m_ps[k] = m_ps[k] + 32'd1;
         if (br)       m_pf[k] = m_pf[k] + 32'd1;
         pipe[k][2] = pipe[k][1];
         pipe[k][1] = pipe[k][0];
         pipe[k][0] = bub ? ins_t'(0) : ins_t'({rd, wr && (rd != 5'd0), ld});
      end
   endtask

   task automatic m_clear();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 3; i++) pipe[k][i] = '0;
         msel_a[k] = 2'd0; msel_b[k] = 2'd0; m_ps[k] = 32'd0; m_pf[k] = 32'd0;
      end
   endtask

   // Starts and ends one time unit after a rising edge.
   task automatic step();
      apply();
      #1;
      for (int k = 0; k < 2; k++) begin
         exp_pre[k] = m_out(k);
         got_pre[k] = got_out(k);
      end
      for (int k = 0; k < 2; k++) m_advance(k);
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         exp_post[k] = m_out(k);
         got_post[k] = got_out(k);
      end
   endtask

   task automatic nops(int n);
      br = 1'b0; mw = 1'b0;
      set_ins(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic test_reset();
      br = 1'b0; mw = 1'b0;
      set_ins(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      reset_n = 1'b0;
      apply();
      m_clear();
      #1;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (got_out(k) !== out_t'(0)) begin
            failures++;
            $display("FAIL reset_state dut%0d got=%h exp=0", k, got_out(k));
         end
      end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic test_alu_fwd();
      nops(1);
      set_ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
      step();
      set_ins(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
      step();
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (got_pre[k].stall !== 1'b0 || got_post[k].sa !== 2'd1) begin
            failures++;
            $display("FAIL alu_fwd_mem dut%0d got stall=%b sel=%0d exp stall=0 sel=1",
                     k, got_pre[k].stall, got_post[k].sa);
         end
      end
      set_ins(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
      step();
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (got_post[k].sa !== 2'd2) begin
            failures++;
            $display("FAIL alu_fwd_wb dut%0d got=%0d exp=2", k, got_post[k].sa);
         end
      end
      set_ins(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      step();
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (got_post[k].sa !== 2'd0) begin
            failures++;
            $display("FAIL alu_fwd_retired dut%0d got=%0d exp=0", k, got_post[k].sa);
         end
      end
   endtask

   task automatic test_reset_midrun();
      set_ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
      step();
      #2;
      reset_n = 1'b0;
      set_ins(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      apply();
      m_clear();
      #1;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (got_out(k) !== out_t'(0)) begin
            failures++;
            $display("FAIL reset_midrun dut%0d got=%h exp=0", k, got_out(k));
         end
      end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic test_load_use();
      nops(3);
      set_ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
      step();
      set_ins(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd9, 1'b1, 1'b0);
      step();
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (got_pre[k].stall !== 1'b1 || got_post[k].exw !== 1'b0 || got_post[k].exr !== 5'd0) begin
            failures++;
            $display("FAIL load_use_stall1 dut%0d got stall=%b exw=%b exr=%0d exp 1,0,0",
                     k, got_pre[k].stall, got_post[k].exw, got_post[k].exr);
         end
      end
      step();
      checks++;
      if (got_pre[0].stall !== 1'b0 || got_post[0].exr !== 5'd9 || got_post[0].sb !== 2'd2) begin
         failures++;
         $display("FAIL load_use_lat1_fwd got stall=%b exr=%0d sel=%0d exp 0,9,2",
                  got_pre[0].stall, got_post[0].exr, got_post[0].sb);
      end
      checks++;
      if (got_pre[1].stall !== 1'b1 || got_post[1].exw !== 1'b0) begin
         failures++;
         $display("FAIL load_use_lat2_stall2 got stall=%b exw=%b exp 1,0",
                  got_pre[1].stall, got_post[1].exw);
      end
      step();
      checks++;
      if (got_pre[1].stall !== 1'b0 || got_post[1].exr !== 5'd9 || got_post[1].sb !== 2'd0) begin
         failures++;
         $display("FAIL load_use_lat2_release got stall=%b exr=%0d sel=%0d exp 0,9,0",
                  got_pre[1].stall, got_post[1].exr, got_post[1].sb);
      end
   endtask

   task automatic test_branch_flush();
      nops(3);
      set_ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
      step();
      set_ins(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd9, 1'b1, 1'b0);
      br = 1'b1;
      step();
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (got_pre[k].stall !== 1'b0 || got_pre[k].fif !== 1'b1 || got_pre[k].fie !== 1'b1) begin
            failures++;
            $display("FAIL branch_flush dut%0d got stall=%b fif=%b fie=%b exp 0,1,1",
                     k, got_pre[k].stall, got_pre[k].fif, got_pre[k].fie);
         end
         checks++;
         if (got_post[k].exw !== 1'b0 || got_post[k].exr !== 5'd0 || got_post[k].sb !== 2'd0) begin
            failures++;
            $display("FAIL branch_bubble dut%0d got exw=%b exr=%0d sel=%0d exp 0,0,0",
                     k, got_post[k].exw, got_post[k].exr, got_post[k].sb);
         end
      end
      br = 1'b0;
   endtask

   task automatic test_r0();
      nops(3);
      set_ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
      step();
      set_ins(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0);
      step();
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (got_pre[k].exw !== 1'b0 || got_pre[k].stall !== 1'b0 || got_post[k].sa !== 2'd0) begin
            failures++;
            $display("FAIL r0_no_hazard dut%0d got exw=%b stall=%b sel=%0d exp 0,0,0",
                     k, got_pre[k].exw, got_pre[k].stall, got_post[k].sa);
         end
      end
   endtask

   task automatic test_mem_wait();
      nops(3);
      set_ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0);
      step();
      set_ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
      step();
      set_ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
      step();
`ifdef HAZARD_PERF_COUNTERS_EN
      snap[0] = ps1; snap[1] = ps2;
`endif
      set_ins(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0);
      mw = 1'b1; br = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (got_pre[k].stall !== 1'b1 || got_pre[k].fie !== 1'b0 || got_post[k].exr !== 5'd4 ||
                got_post[k].memr !== 5'd7 || got_post[k].wbr !== 5'd2) begin
               failures++;
               $display("FAIL mem_wait_hold dut%0d cyc%0d got stall=%b fie=%b ex=%0d mem=%0d wb=%0d exp 1,0,4,7,2",
                        k, c, got_pre[k].stall, got_pre[k].fie, got_post[k].exr,
                        got_post[k].memr, got_post[k].wbr);
            end
         end
      end
`ifdef HAZARD_PERF_COUNTERS_EN
      checks++;
      if (ps1 !== snap[0] || ps2 !== snap[1]) begin
         failures++;
         $display("FAIL perf_during_wait got %0d/%0d exp %0d/%0d", ps1, ps2, snap[0], snap[1]);
      end
`endif
      mw = 1'b0; br = 1'b0;
      step();
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (got_pre[k].stall !== 1'b1 || got_post[k].memr !== 5'd4 || got_post[k].wbr !== 5'd7) begin
            failures++;
            $display("FAIL mem_wait_resume dut%0d got stall=%b mem=%0d wb=%0d exp 1,4,7",
                     k, got_pre[k].stall, got_post[k].memr, got_post[k].wbr);
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         set_ins(($urandom_range(0, 7) != 0), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
         br = ($urandom_range(0, 7) == 0);
         mw = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 99) == 0) begin
            reset_n = 1'b0;
            apply();
            m_clear();
            #1;
            for (int k = 0; k < 2; k++) begin
               checks++;
               if (got_out(k) !== m_out(k)) begin
                  failures++;
                  $display("FAIL rand_reset dut%0d n=%0d got=%h exp=%h", k, n, got_out(k), m_out(k));
               end
            end
            @(posedge clk);
            #1;
            reset_n = 1'b1;
         end else begin
            step();
            for (int k = 0; k < 2; k++) begin
               checks++;
               if (got_pre[k] !== exp_pre[k]) begin
                  failures++;
                  $display("FAIL rand_comb dut%0d n=%0d got=%h exp=%h", k, n, got_pre[k], exp_pre[k]);
               end
               checks++;
               if (got_post[k] !== exp_post[k]) begin
                  failures++;
                  $display("FAIL rand_edge dut%0d n=%0d got=%h exp=%h", k, n, got_post[k], exp_post[k]);
               end
            end
         end
      end
`ifdef HAZARD_PERF_COUNTERS_EN
      checks++;
      if (ps1 !== m_ps[0] || pf1 !== m_pf[0] || ps2 !== m_ps[1] || pf2 !== m_pf[1]) begin
         failures++;
         $display("FAIL perf_counts got %0d,%0d,%0d,%0d exp %0d,%0d,%0d,%0d",
                  ps1, pf1, ps2, pf2, m_ps[0], m_pf[0], m_ps[1], m_pf[1]);
      end
`endif
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_alu_fwd();
      test_reset_midrun();
      test_load_use();
      test_branch_flush();
      test_r0();
      test_mem_wait();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
